// File: rtl/acc_temp_pkg.sv
// Shared opcodes and width helper for the accumulator/temp register bank.
package acc_temp_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDA  = 3'd1;
    localparam logic [2:0] OP_STT  = 3'd2;
    localparam logic [2:0] OP_LDT  = 3'd3;
    localparam logic [2:0] OP_XCH  = 3'd4;
    localparam logic [2:0] OP_PUSH = 3'd5;
    localparam logic [2:0] OP_POP  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    // Index width for an n-entry array, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_lifo.sv
// Save LIFO for ACC: push/pop take effect on the next edge, top entry readable combinationally.
// No backpressure: push when full / pop when empty are dropped and reported as ovf/unf pulses.
module acc_lifo
    import acc_temp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf
);

    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int AW   = idx_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNTW-1:0]  top;
    logic             pushOk;
    logic             popOk;

    assign full   = (count == CNTW'(DEPTH));
    assign empty  = (count == '0);
    assign pushOk = push & ~full;
    assign popOk  = pop & ~empty;
    assign ovf    = push & full;
    assign unf    = pop & empty;

    // Clamp the top index when empty so the read never leaves the array.
    assign top  = empty ? '0 : (count - CNTW'(1));
    assign dout = mem[top[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (pushOk) begin
            count <= count + CNTW'(1);
        end else if (popOk) begin
            count <= count - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[count[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/acc_temp_bank.sv
// ACC + carry, indexed temp file and ACC save LIFO; one op per cycle, results visible next cycle.
// No backpressure: every valid op executes; illegal push/pop only raise sticky error flags.
module acc_temp_bank
    import acc_temp_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NTEMP       = 2,
    parameter int STACK_DEPTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               opValid,
    input  logic [2:0]                         op,
    input  logic [idx_bits(NTEMP)-1:0]         tempIdx,
    input  logic [WIDTH-1:0]                   aluResult,
    input  logic                               aluCarry,
    input  logic                               errClr,
    output logic [WIDTH-1:0]                   accOut,
    output logic                               carryOut,
    output logic [WIDTH-1:0]                   tempOut,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stackCount,
    output logic                               stackFull,
    output logic                               stackEmpty,
    output logic                               errOvf,
    output logic                               errUnf
);

    localparam int IDXW = idx_bits(NTEMP);

    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [WIDTH-1:0] temp [NTEMP];
    logic [WIDTH-1:0] accNxt;
    logic             carryNxt;
    logic             tempWe;
    logic             idxOk;
    logic [WIDTH-1:0] tempRd;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] popDat;
    logic             lifoOvf;
    logic             lifoUnf;

    // Only matters for non-power-of-two NTEMP, where some indices have no entry.
    assign idxOk  = ({1'b0, tempIdx} < (IDXW + 1)'(NTEMP));
    assign tempRd = idxOk ? temp[tempIdx] : '0;

    always_comb begin
        accNxt   = acc;
        carryNxt = carry;
        tempWe   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (opValid) begin
            case (op)
                OP_LDA: begin
                    accNxt   = aluResult;
                    carryNxt = aluCarry;
                end
                OP_STT: tempWe = idxOk;
                OP_LDT: if (idxOk) accNxt = tempRd;
                OP_XCH: begin
                    if (idxOk) begin
                        accNxt = tempRd;
                        tempWe = 1'b1;
                    end
                end
                OP_PUSH: push = 1'b1;
                OP_POP: begin
                    pop = 1'b1;
                    if (!stackEmpty) accNxt = popDat;
                end
                OP_CLR: begin
                    accNxt   = '0;
                    carryNxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Temp write data is always the pre-edge ACC, which makes XCH a true swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            carry  <= 1'b0;
            errOvf <= 1'b0;
            errUnf <= 1'b0;
            for (int i = 0; i < NTEMP; i++) temp[i] <= '0;
        end else begin
            acc    <= accNxt;
            carry  <= carryNxt;
            errOvf <= lifoOvf | (errOvf & ~errClr);
            errUnf <= lifoUnf | (errUnf & ~errClr);
            if (tempWe) temp[tempIdx] <= acc;
        end
    end

    acc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (acc),
        .dout  (popDat),
        .count (stackCount),
        .full  (stackFull),
        .empty (stackEmpty),
        .ovf   (lifoOvf),
        .unf   (lifoUnf)
    );

    assign accOut   = acc;
    assign carryOut = carry;
    assign tempOut  = tempRd;

endmodule

// File: tb/tb_acc_temp_bank.sv
// Directed + random bench for acc_temp_bank with a queue-based reference model checked every cycle.
module tb_acc_temp_bank;

    localparam logic [2:0] NOP = 3'd0, LDA = 3'd1, STT = 3'd2, LDT = 3'd3;
    localparam logic [2:0] XCH = 3'd4, PUSH = 3'd5, POP = 3'd6, CLR = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       opValid = 1'b0;
    logic [2:0] op = 3'd0;
    logic       tempIdx = 1'b0;
    logic [3:0] aluResult = 4'd0;
    logic       aluCarry = 1'b0;
    logic       errClr = 1'b0;
    logic [3:0] accOut;
    logic       carryOut;
    logic [3:0] tempOut;
    logic [1:0] stackCount;
    logic       stackFull;
    logic       stackEmpty;
    logic       errOvf;
    logic       errUnf;

    int checks = 0;
    int errors = 0;

    acc_temp_bank #(.WIDTH(4), .NTEMP(2), .STACK_DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .opValid    (opValid),
        .op         (op),
        .tempIdx    (tempIdx),
        .aluResult  (aluResult),
        .aluCarry   (aluCarry),
        .errClr     (errClr),
        .accOut     (accOut),
        .carryOut   (carryOut),
        .tempOut    (tempOut),
        .stackCount (stackCount),
        .stackFull  (stackFull),
        .stackEmpty (stackEmpty),
        .errOvf     (errOvf),
        .errUnf     (errUnf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain registers, a two-entry temp array and a queue as the LIFO.
    logic [3:0] mAcc;
    logic       mCarry;
    logic [3:0] mTemp [2];
    logic [3:0] mStack [$];
    logic       mOvf;
    logic       mUnf;
    bit         modelOn = 0;

    task automatic model_edge();
        logic [3:0] oldAcc;
        bit ovfSet, unfSet;
        if (rst) begin
            mAcc = 0; mCarry = 0; mTemp[0] = 0; mTemp[1] = 0;
            mStack.delete(); mOvf = 0; mUnf = 0;
            return;
        end
        oldAcc = mAcc;
        ovfSet = 0;
        unfSet = 0;
        if (opValid) begin
            case (op)
                LDA: begin mAcc = aluResult; mCarry = aluCarry; end
                STT: mTemp[tempIdx] = oldAcc;
                LDT: mAcc = mTemp[tempIdx];
                XCH: begin mAcc = mTemp[tempIdx]; mTemp[tempIdx] = oldAcc; end
                PUSH: if (mStack.size() == 3) ovfSet = 1; else mStack.push_back(oldAcc);
                POP: if (mStack.size() == 0) unfSet = 1; else mAcc = mStack.pop_back();
                CLR: begin mAcc = 0; mCarry = 0; end
                default: ;
            endcase
        end
        mOvf = ovfSet ? 1'b1 : (errClr ? 1'b0 : mOvf);
        mUnf = unfSet ? 1'b1 : (errClr ? 1'b0 : mUnf);
    endtask

    always @(posedge clk) begin
        if (modelOn) begin
            model_edge();
            #1;
            chk("acc", accOut, mAcc);
            chk("carry", carryOut, mCarry);
            chk("temp", tempOut, mTemp[tempIdx]);
            chk("count", stackCount, mStack.size());
            chk("full", stackFull, mStack.size() == 3);
            chk("empty", stackEmpty, mStack.size() == 0);
            chk("ovf", errOvf, mOvf);
            chk("unf", errUnf, mUnf);
            chk("count_range", stackCount <= 2'd3, 1);
            chk("full_and_empty", stackFull && stackEmpty, 0);
        end
    end

    task automatic do_op(input logic v, input logic [2:0] o, input logic i,
                         input logic [3:0] a, input logic c, input logic clr);
        @(negedge clk);
        opValid = v; op = o; tempIdx = i; aluResult = a; aluCarry = c; errClr = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        opValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        modelOn = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_acc", accOut, 4'h0);
        chk("rst_empty", stackEmpty, 1'b1);
        chk("rst_count", stackCount, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1. async reset mid-stream
        do_op(1, LDA, 0, 4'h9, 0, 0);
        chk("t1_lda9", accOut, 4'h9);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_async_acc", accOut, 4'h0);
        chk("t1_async_empty", stackEmpty, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op(1, LDA, 0, 4'hA, 1, 0);
        chk("t1_ldaA", accOut, 4'hA);
        chk("t1_carry", carryOut, 1'b1);

        // 2. store / exchange
        do_op(1, LDA, 1, 4'h5, 0, 0);
        do_op(1, STT, 1, 4'h0, 0, 0);
        do_op(1, LDA, 1, 4'h3, 0, 0);
        do_op(1, XCH, 1, 4'h0, 0, 0);
        chk("t2_xch_acc", accOut, 4'h5);
        chk("t2_xch_temp", tempOut, 4'h3);

        // 3. fill, overflow, drain
        for (int k = 1; k <= 3; k++) begin
            do_op(1, LDA, 0, 4'(k), 0, 0);
            do_op(1, PUSH, 0, 4'h0, 0, 0);
        end
        chk("t3_full", stackFull, 1'b1);
        chk("t3_count", stackCount, 2'd3);
        do_op(1, PUSH, 0, 4'h0, 0, 0);
        chk("t3_ovf", errOvf, 1'b1);
        chk("t3_count_ovf", stackCount, 2'd3);
        for (int k = 3; k >= 1; k--) begin
            do_op(1, POP, 0, 4'h0, 0, 0);
            chk("t3_pop", accOut, 4'(k));
        end
        chk("t3_empty", stackEmpty, 1'b1);

        // 4. underflow and clear priority
        do_op(1, POP, 0, 4'h0, 0, 0);
        chk("t4_unf", errUnf, 1'b1);
        chk("t4_acc_kept", accOut, 4'h1);
        do_op(1, POP, 0, 4'h0, 0, 1);
        chk("t4_set_wins", errUnf, 1'b1);
        chk("t4_ovf_cleared", errOvf, 1'b0);
        do_op(0, NOP, 0, 4'h0, 0, 1);
        chk("t4_unf_cleared", errUnf, 1'b0);

        // 5. opValid gating, clear, LDT after reset
        do_op(1, LDA, 0, 4'h7, 1, 0);
        do_op(0, CLR, 0, 4'h0, 0, 0);
        chk("t5_gated", accOut, 4'h7);
        do_op(1, CLR, 0, 4'h0, 0, 0);
        chk("t5_clr_acc", accOut, 4'h0);
        chk("t5_clr_carry", carryOut, 1'b0);
        apply_reset();
        do_op(1, LDA, 0, 4'h7, 0, 0);
        do_op(1, LDT, 0, 4'h0, 0, 0);
        chk("t5_ldt0", accOut, 4'h0);

        // 6. random stream against the model
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 999) == 0);
            opValid   = ($urandom_range(0, 9) < 8);
            op        = 3'($urandom_range(0, 7));
            tempIdx   = 1'($urandom_range(0, 1));
            aluResult = 4'($urandom_range(0, 15));
            aluCarry  = 1'($urandom_range(0, 1));
            errClr    = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        opValid = 1'b0;
        errClr = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
